// File: rtl/toe_host_sequencer.sv
// Avalon-MM master that loads a connection descriptor into the TOE registers,
// issues the open request, polls status until not busy, then clears the request.
module toe_host_sequencer #(
    parameter logic [31:0] BUSY_CODE = 32'h0000_D240,
    parameter logic [31:0] REQ_OPEN  = 32'h4000_0000,
    parameter int unsigned MAX_POLLS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ip_src,
    input  logic [31:0] ip_dst,
    input  logic [47:0] mac_src,
    input  logic [47:0] mac_dst,
    input  logic [15:0] port_src,
    input  logic [15:0] port_dst,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] status,
    output logic        chipselect,
    output logic        write,
    output logic        read,
    output logic [3:0]  address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR        = 3'd1;
    localparam logic [2:0] S_GAP       = 3'd2;
    localparam logic [2:0] S_POLL_RD   = 3'd3;
    localparam logic [2:0] S_POLL_WAIT = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // Steps 0..6 are descriptor words, 7 is the open request, 8 the clear.
    localparam logic [3:0]  STEP_REQ   = 4'd7;
    localparam logic [3:0]  STEP_CLR   = 4'd8;
    localparam logic [16:0] POLL_LIMIT = 17'(MAX_POLLS);

    logic [2:0]  r_state;
    logic [3:0]  r_step;
    logic [15:0] r_polls;
    logic [31:0] r_ip_dst;
    logic [47:0] r_mac_src;
    logic [47:0] r_mac_dst;
    logic [15:0] r_port_src;
    logic [15:0] r_port_dst;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_status;
    logic        r_cs;
    logic        r_write;
    logic        r_read;
    logic [3:0]  r_address;
    logic [31:0] r_writedata;

    logic [3:0]  w_next_step;
    logic [3:0]  w_next_addr;
    logic [31:0] w_next_data;
    logic [16:0] w_polls_inc;

    always_comb begin
        w_next_step = r_step + 4'd1;
        w_polls_inc = {1'b0, r_polls} + 17'd1;
        w_next_addr = '0;
        w_next_data = '0;
        case (w_next_step)
            4'd1: begin w_next_addr = 4'd4; w_next_data = r_ip_dst;                   end
            4'd2: begin w_next_addr = 4'd5; w_next_data = r_mac_src[47:16];           end
            4'd3: begin w_next_addr = 4'd6; w_next_data = {r_mac_src[15:0], 16'h0};   end
            4'd4: begin w_next_addr = 4'd7; w_next_data = r_mac_dst[47:16];           end
            4'd5: begin w_next_addr = 4'd8; w_next_data = {r_mac_dst[15:0], 16'h0};   end
            4'd6: begin w_next_addr = 4'd9; w_next_data = {r_port_src, r_port_dst};   end
            4'd7: begin w_next_addr = 4'd0; w_next_data = REQ_OPEN;                   end
            default: begin w_next_addr = 4'd0; w_next_data = '0;                      end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_polls     <= '0;
            r_ip_dst    <= '0;
            r_mac_src   <= '0;
            r_mac_dst   <= '0;
            r_port_src  <= '0;
            r_port_dst  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_status    <= '0;
            r_cs        <= 1'b0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // ip_src goes straight onto the bus, so it needs no holding register.
                        r_ip_dst    <= ip_dst;
                        r_mac_src   <= mac_src;
                        r_mac_dst   <= mac_dst;
                        r_port_src  <= port_src;
                        r_port_dst  <= port_dst;
                        r_step      <= '0;
                        r_polls     <= '0;
                        r_timeout   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cs        <= 1'b1;
                        r_write     <= 1'b1;
                        r_address   <= 4'd3;
                        r_writedata <= ip_src;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    r_cs    <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_step == STEP_CLR) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_step == STEP_REQ) begin
                        r_cs      <= 1'b1;
                        r_read    <= 1'b1;
                        r_address <= 4'd2;
                        r_state   <= S_POLL_RD;
                    end else begin
                        r_step      <= w_next_step;
                        r_cs        <= 1'b1;
                        r_write     <= 1'b1;
                        r_address   <= w_next_addr;
                        r_writedata <= w_next_data;
                        r_state     <= S_WR;
                    end
                end
                S_POLL_RD: begin
                    r_cs    <= 1'b0;
                    r_read  <= 1'b0;
                    r_state <= S_POLL_WAIT;
                end
                S_POLL_WAIT: begin
                    r_status <= readdata;
                    r_polls  <= w_polls_inc[15:0];
                    if (readdata != BUSY_CODE || w_polls_inc == POLL_LIMIT) begin
                        r_timeout   <= (readdata == BUSY_CODE);
                        r_step      <= STEP_CLR;
                        r_cs        <= 1'b1;
                        r_write     <= 1'b1;
                        r_address   <= 4'd0;
                        r_writedata <= '0;
                        r_state     <= S_WR;
                    end else begin
                        r_cs    <= 1'b1;
                        r_read  <= 1'b1;
                        r_state <= S_POLL_RD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign status     = r_status;
    assign chipselect = r_cs;
    assign write      = r_write;
    assign read       = r_read;
    assign address    = r_address;
    assign writedata  = r_writedata;

endmodule

// File: tb/tb_toe_host_sequencer.sv
// Table-driven and randomized bench for toe_host_sequencer with an Avalon slave
// model and a transaction-level reference of the expected register traffic.
module tb_toe_host_sequencer;

    localparam int unsigned MAXP = 4;
    localparam logic [31:0] BUSY = 32'h0000_D240;
    localparam logic [31:0] REQO = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ip_src, ip_dst;
    logic [47:0] mac_src, mac_dst;
    logic [15:0] port_src, port_dst;
    logic        busy, done, timeout;
    logic [31:0] status;
    logic        chipselect, write, read;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    always #5 clk = ~clk;

    toe_host_sequencer #(
        .BUSY_CODE (BUSY),
        .REQ_OPEN  (REQO),
        .MAX_POLLS (MAXP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ip_src     (ip_src),
        .ip_dst     (ip_dst),
        .mac_src    (mac_src),
        .mac_dst    (mac_dst),
        .port_src   (port_src),
        .port_dst   (port_dst),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .status     (status),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    typedef struct {
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [47:0] mac_src;
        logic [47:0] mac_dst;
        logic [15:0] psrc;
        logic [15:0] pdst;
        int          nbusy;
        logic [31:0] fin;
        bit          spam;
        logic [31:0] exp_status;
        logic        exp_to;
        int          exp_done;
    } vec_t;

    txn_t got_q[$];
    txn_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_n = 0;
    int   e0 = 0;
    int   rd_cnt = 0;
    int   slave_nbusy = 0;
    logic [31:0] slave_final = '0;
    int   busy_cycles = 0;
    int   proto_err = 0;
    int   cs_cnt = 0;
    int   done_cnt = 0;
    logic prev_write = 1'b0;
    logic [3:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    // Slave: answers the first slave_nbusy reads with BUSY, then slave_final.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (chipselect && read) begin
            readdata <= (rd_cnt < slave_nbusy) ? BUSY : slave_final;
            rd_cnt = rd_cnt + 1;
        end else begin
            readdata <= 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (chipselect) begin
            got_q.push_back('{write, address, write ? writedata : 32'h0, edge_n - e0});
            cs_cnt = cs_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (busy) busy_cycles = busy_cycles + 1;
        if (write && read) proto_err = proto_err + 1;
        if (chipselect != (write || read)) proto_err = proto_err + 1;
        if (prev_write && (chipselect || address != prev_addr || writedata != prev_data))
            proto_err = proto_err + 1;
        prev_write = chipselect && write;
        prev_addr  = address;
        prev_data  = writedata;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input txn_t t);
        return {11'b0, t.we, t.addr, t.data, 16'(t.cyc)};
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {57'b0, busy, done, timeout, chipselect, write, read, address}, '0);
        check({name, "_data"}, {status, writedata}, '0);
    endtask

    // Reference: every bus cycle takes two clocks (access + idle), starting at cycle 1.
    task automatic build_expected(input vec_t v);
        logic [31:0] words[7];
        int c;
        int nreads;
        words[0] = v.ip_src;
        words[1] = v.ip_dst;
        words[2] = v.mac_src[47:16];
        words[3] = {v.mac_src[15:0], 16'h0};
        words[4] = v.mac_dst[47:16];
        words[5] = {v.mac_dst[15:0], 16'h0};
        words[6] = {v.psrc, v.pdst};
        exp_q.delete();
        c = 1;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back('{1'b1, 4'(3 + k), words[k], c});
            c = c + 2;
        end
        exp_q.push_back('{1'b1, 4'd0, REQO, c});
        c = c + 2;
        nreads = (v.nbusy + 1 < int'(MAXP)) ? v.nbusy + 1 : int'(MAXP);
        for (int r = 0; r < nreads; r++) begin
            exp_q.push_back('{1'b0, 4'd2, 32'h0, c});
            c = c + 2;
        end
        exp_q.push_back('{1'b1, 4'd0, 32'h0, c});
    endtask

    task automatic run_seq(input vec_t v, input string tag);
        int dc;
        bit got_done;
        int nq;
        @(negedge clk);
        got_q.delete();
        busy_cycles = 0;
        proto_err = 0;
        rd_cnt = 0;
        slave_nbusy = v.nbusy;
        slave_final = v.fin;
        e0 = edge_n;
        ip_src = v.ip_src; ip_dst = v.ip_dst;
        mac_src = v.mac_src; mac_dst = v.mac_dst;
        port_src = v.psrc; port_dst = v.pdst;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ip_src = $urandom; ip_dst = $urandom;
        mac_src = {16'($urandom), $urandom}; mac_dst = {16'($urandom), $urandom};
        port_src = 16'($urandom); port_dst = 16'($urandom);
        check({tag, "_accept_busy"}, 64'(busy), 64'd1);
        check({tag, "_accept_timeout_clr"}, 64'(timeout), 64'd0);
        got_done = 1'b0;
        dc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                dc = edge_n - e0;
                break;
            end
            if (v.spam) start = ($urandom_range(0, 1) == 1);
        end
        start = v.spam;
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_done_cycle"}, 64'(dc), 64'(v.exp_done));
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
        check({tag, "_status"}, 64'(status), 64'(v.exp_status));
        check({tag, "_timeout"}, 64'(timeout), 64'(v.exp_to));
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(v.exp_done - 1));
        check({tag, "_protocol"}, 64'(proto_err), 64'd0);
        build_expected(v);
        check({tag, "_n_txn"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_txn%0d", tag, i), pk(got_q[i]), pk(exp_q[i]));
        if (!v.spam) begin
            nq = got_q.size();
            repeat (3) @(negedge clk);
            check({tag, "_hold_status"}, 64'(status), 64'(v.exp_status));
            check({tag, "_hold_timeout"}, 64'(timeout), 64'(v.exp_to));
            check({tag, "_hold_idle"}, 64'(got_q.size()), 64'(nq));
        end
    endtask

    vec_t tbl[4];
    vec_t rv;

    initial begin
        tbl[0] = '{32'h11111111, 32'h22222222, 48'h333333333333, 48'h444444444444,
                   16'h5555, 16'h6666, 0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 21};
        tbl[1] = '{32'h11111111, 32'h22222222, 48'h333333333333, 48'h444444444444,
                   16'h5555, 16'h6666, 3, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0, 27};
        tbl[2] = '{32'hC0A80001, 32'hC0A80002, 48'h0A1B2C3D4E5F, 48'hF0E1D2C3B4A5,
                   16'h1234, 16'h0050, 99, 32'h0000_0077, 1'b1, BUSY, 1'b1, 27};
        tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 48'h800000000001, 48'h000000010000,
                   16'hFFFF, 16'h0001, 0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 21};

        rst = 1'b1;
        start = 1'b0;
        ip_src = '0; ip_dst = '0; mac_src = '0; mac_dst = '0; port_src = '0; port_dst = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_seq(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 8; i++) begin
            rv.ip_src = $urandom; rv.ip_dst = $urandom;
            rv.mac_src = {16'($urandom), $urandom}; rv.mac_dst = {16'($urandom), $urandom};
            rv.psrc = 16'($urandom); rv.pdst = 16'($urandom);
            rv.nbusy = $urandom_range(0, 5);
            rv.fin = $urandom;
            if (rv.fin == BUSY) rv.fin = rv.fin ^ 32'h1;
            rv.spam = ($urandom_range(0, 1) == 1);
            rv.exp_to = (rv.nbusy >= int'(MAXP));
            rv.exp_status = rv.exp_to ? BUSY : rv.fin;
            rv.exp_done = 19 + 2 * ((rv.nbusy + 1 < int'(MAXP)) ? rv.nbusy + 1 : int'(MAXP));
            run_seq(rv, $sformatf("rnd%0d", i));
        end

        // Reset during the poll phase, then confirm silence and a clean rerun.
        @(negedge clk);
        start = 1'b0;
        rd_cnt = 0;
        slave_nbusy = 99;
        ip_src = tbl[0].ip_src; ip_dst = tbl[0].ip_dst;
        mac_src = tbl[0].mac_src; mac_dst = tbl[0].mac_dst;
        port_src = tbl[0].psrc; port_dst = tbl[0].pdst;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit saw_read;
            int cs0, dn0;
            saw_read = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (chipselect && read) begin saw_read = 1'b1; break; end
            end
            check("rst_mid_reached_poll", 64'(saw_read), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            check_all_zero("rst_mid");
            rst = 1'b0;
            cs0 = cs_cnt;
            dn0 = done_cnt;
            repeat (30) @(negedge clk);
            check("rst_mid_no_bus", 64'(cs_cnt - cs0), 64'd0);
            check("rst_mid_no_done", 64'(done_cnt - dn0), 64'd0);
        end
        run_seq(tbl[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
